q_table_store: RTL and testbench

Q-table storage and read/write-back companion to the Bellman Q-updater. It answers state reads with the four action Q-values and their argmax action, so the updater can be fed. It captures the (state, action) of every update issued to the updater and writes the returned Qnew back into the table after the updater's fixed latency. One instance serves one agent; double-agent designs instantiate two.

---
 rtl/q_table_store_if.sv | 28 ++
 rtl/q_table_store.sv | 90 +++++++++
 tb/tb_q_table_store.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/q_table_store_if.sv
// rtl/q_table_store_if.sv - read, update-issue and write-back signals between the Q-updater side and the Q-table store.
interface q_table_store_if #(
  parameter int SW = 4
);
  logic          rd_valid;
  logic [SW-1:0] rd_state;
  logic          q_valid;
  logic [31:0]   Q0;
  logic [31:0]   Q1;
  logic [31:0]   Q2;
  logic [31:0]   Q3;
  logic [1:0]    Amax;
  logic          upd_valid;
  logic [SW-1:0] upd_state;
  logic [1:0]    upd_action;
  logic [31:0]   Qnew;
  logic [15:0]   wr_count;

  modport master (
    output rd_valid, rd_state, upd_valid, upd_state, upd_action, Qnew,
    input  q_valid, Q0, Q1, Q2, Q3, Amax, wr_count
  );

  modport slave (
    input  rd_valid, rd_state, upd_valid, upd_state, upd_action, Qnew,
    output q_valid, Q0, Q1, Q2, Q3, Amax, wr_count
  );
endinterface

// File: rtl/q_table_store.sv
// rtl/q_table_store.sv - Q-table with registered row read + argmax and delayed write-back of updater results.
module q_table_store #(
  parameter int N_STATES = 16,
  parameter int SW       = 4,
  parameter int UPD_LAT  = 6
) (
  input logic              clk,
  input logic              rst,
  q_table_store_if.slave   bus
);
  localparam int TAIL = UPD_LAT - 1;

  logic [31:0]        tbl  [N_STATES][4];
  logic [UPD_LAT-1:0] dl_v;
  logic [SW-1:0]      dl_s [UPD_LAT];
  logic [1:0]         dl_a [UPD_LAT];

  logic        wr_en;
  logic        rd_hit;
  logic [31:0] row [4];
  logic [1:0]  amax_idx;

  assign wr_en = dl_v[TAIL] && (32'(dl_s[TAIL]) < N_STATES);

  // Only the valid bits need clearing; stale state/action is never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
    end else begin
      dl_v[0] <= bus.upd_valid;
      for (int i = 1; i < UPD_LAT; i++) dl_v[i] <= dl_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_s[0] <= bus.upd_state;
    dl_a[0] <= bus.upd_action;
    for (int i = 1; i < UPD_LAT; i++) begin
      dl_s[i] <= dl_s[i-1];
      dl_a[i] <= dl_a[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_STATES; s++)
        for (int c = 0; c < 4; c++) tbl[s][c] <= '0;
    end else if (wr_en) begin
      tbl[dl_s[TAIL]][dl_a[TAIL]] <= bus.Qnew;
    end
  end

  // Row as it will look after this edge's write-back, so a same-cycle read sees Qnew.
  always_comb begin
    rd_hit = 32'(bus.rd_state) < N_STATES;
    for (int c = 0; c < 4; c++) begin
      row[c] = rd_hit ? tbl[bus.rd_state][c] : '0;
      if (wr_en && dl_s[TAIL] == bus.rd_state && dl_a[TAIL] == 2'(c))
        row[c] = bus.Qnew;
    end
  end

  always_comb begin
    amax_idx = 2'd0;
    for (int c = 1; c < 4; c++)
      if ($signed(row[c]) > $signed(row[amax_idx])) amax_idx = 2'(c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q_valid  <= 1'b0;
      bus.Q0       <= '0;
      bus.Q1       <= '0;
      bus.Q2       <= '0;
      bus.Q3       <= '0;
      bus.Amax     <= '0;
      bus.wr_count <= '0;
    end else begin
      bus.q_valid <= bus.rd_valid;
      if (bus.rd_valid) begin
        bus.Q0   <= row[0];
        bus.Q1   <= row[1];
        bus.Q2   <= row[2];
        bus.Q3   <= row[3];
        bus.Amax <= amax_idx;
      end
      if (wr_en) bus.wr_count <= bus.wr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_q_table_store.sv
// tb/tb_q_table_store.sv - directed self-checking bench for q_table_store.
module tb_q_table_store;
  localparam int N_STATES = 12;
  localparam int SW       = 4;
  localparam int UPD_LAT  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  q_table_store_if #(.SW(SW)) bus ();

  q_table_store #(.N_STATES(N_STATES), .SW(SW), .UPD_LAT(UPD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] s, input logic [1:0] a, input logic [31:0] v);
    bus.upd_valid  = 1'b1;
    bus.upd_state  = s;
    bus.upd_action = a;
    bus.Qnew       = v;
    tick();
    bus.upd_valid = 1'b0;
    repeat (UPD_LAT) tick();
  endtask

  task automatic do_read(input logic [3:0] s);
    bus.rd_valid = 1'b1;
    bus.rd_state = s;
    tick();
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    bus.rd_valid   = 1'b0;
    bus.rd_state   = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_state  = '0;
    bus.upd_action = '0;
    bus.Qnew       = '0;

    // Reset and reset read
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    do_read(4'd3);
    check("rd3_q_valid", 32'(bus.q_valid), 32'd1);
    check("rd3_Q0", bus.Q0, 32'd0);
    check("rd3_Q3", bus.Q3, 32'd0);
    check("rd3_Amax", 32'(bus.Amax), 32'd0);
    tick();
    check("idle_q_valid", 32'(bus.q_valid), 32'd0);

    // Basic write-back with in-flight read at t+3 and forwarded read at t+6
    bus.upd_valid = 1'b1; bus.upd_state = 4'd5; bus.upd_action = 2'd2; bus.Qnew = 32'h100;
    tick();
    bus.upd_valid = 1'b0;
    tick(); tick();
    do_read(4'd5);
    check("inflight_Q2", bus.Q2, 32'd0);
    check("inflight_wr_count", 32'(bus.wr_count), 32'd0);
    tick(); tick();
    do_read(4'd5);
    check("fwd_Q2", bus.Q2, 32'h100);
    check("fwd_Amax", 32'(bus.Amax), 32'd2);
    check("fwd_wr_count", 32'(bus.wr_count), 32'd1);
    do_read(4'd5);
    check("wb_Q0", bus.Q0, 32'd0);
    check("wb_Q2", bus.Q2, 32'h100);
    check("wb_Amax", 32'(bus.Amax), 32'd2);

    // Argmax: signed compare, tie goes to lower index
    do_write(4'd1, 2'd0, 32'hFFFF_FFF0);
    do_write(4'd1, 2'd1, 32'h10);
    do_write(4'd1, 2'd2, 32'h10);
    do_write(4'd1, 2'd3, 32'h8);
    do_read(4'd1);
    check("amax_signed_Q0", bus.Q0, 32'hFFFF_FFF0);
    check("amax_signed", 32'(bus.Amax), 32'd1);
    check("amax_wr_count", 32'(bus.wr_count), 32'd5);
    for (int c = 0; c < 4; c++) do_write(4'd1, 2'(c), 32'h8000_0000);
    do_read(4'd1);
    check("amax_min_Q3", bus.Q3, 32'h8000_0000);
    check("amax_all_equal", 32'(bus.Amax), 32'd0);

    // Back-to-back updates to the same cell, last one wins
    bus.upd_valid = 1'b1; bus.upd_state = 4'd7; bus.upd_action = 2'd0;
    tick(); tick();
    bus.upd_valid = 1'b0;
    repeat (UPD_LAT - 2) tick();
    bus.Qnew = 32'hA;
    tick();
    bus.Qnew = 32'hB;
    tick();
    bus.Qnew = 32'h0;
    do_read(4'd7);
    check("b2b_Q0", bus.Q0, 32'hB);
    check("b2b_wr_count", 32'(bus.wr_count), 32'd11);

    // Out-of-range write dropped, out-of-range read returns zeros
    do_write(4'd14, 2'd1, 32'h77);
    check("oor_wr_count", 32'(bus.wr_count), 32'd11);
    do_read(4'd14);
    check("oor_q_valid", 32'(bus.q_valid), 32'd1);
    check("oor_Q1", bus.Q1, 32'd0);
    check("oor_Amax", 32'(bus.Amax), 32'd0);
    do_read(4'd13);
    check("oor13_Q0", bus.Q0, 32'd0);

    // Reset while an update is in flight
    bus.upd_valid = 1'b1; bus.upd_state = 4'd9; bus.upd_action = 2'd3; bus.Qnew = 32'h55;
    tick();
    bus.upd_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (UPD_LAT) tick();
    bus.Qnew = 32'h0;
    check("rstfl_wr_count", 32'(bus.wr_count), 32'd0);
    do_read(4'd9);
    check("rstfl_Q3", bus.Q3, 32'd0);
    do_read(4'd7);
    check("rstfl_row7_cleared", bus.Q0, 32'd0);
    do_read(4'd5);
    check("rstfl_row5_cleared", bus.Q2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
